// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//   MEM-stage data-memory access controller. Sits between the EX/MEM
//   pipeline flop and MEM_WB_FF. Each load or store is turned into exactly
//   one request on a req/ack handshake to a variable-latency data memory.
//   The pipeline is stalled until the ack arrives or a timeout expires.
//   Load data is registered and presented to MEM_WB_FF together with the
//   combinational pass-through of the ALU result and writeback select.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   alu_result_EX       ALU result; address for loads and stores
//   sdata_EX            store data
//   mem_re_EX/_we_EX    load / store present in MEM stage
//   wb_sel_EX           writeback select (passed through)
//   ext_stall           stall from elsewhere in the pipeline
//   mem_req/wr/addr/wdata  registered request to data memory
//   mem_rdata, mem_ack  read data and one-cycle completion strobe
//   ldata_MEM           registered load data to MEM_WB_FF
//   alu_result_MEM      = alu_result_EX
//   wb_sel_MEM          = wb_sel_EX
//   mem_stall           stall request to upstream flops and MEM_WB_FF
//   mem_err             one-cycle pulse on timeout or re&we both set
//   stall_cnt           saturating count of cycles with mem_stall high
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                TIMEOUT  = 255,
  parameter int                CNT_W    = 8,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(16'hDEAD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu_result_EX,
  input  logic [DATA_W-1:0] sdata_EX,
  input  logic              mem_re_EX,
  input  logic              mem_we_EX,
  input  logic              wb_sel_EX,
  input  logic              ext_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ldata_MEM,
  output logic [DATA_W-1:0] alu_result_MEM,
  output logic              wb_sel_MEM,
  output logic              mem_stall,
  output logic              mem_err,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value seen on the last permitted WAIT cycle; reaching it
  // without an ack forces completion.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             mem_op;
  logic             issue;
  logic             ack_take;
  logic             tmo_hit;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign alu_result_MEM = alu_result_EX;
  assign wb_sel_MEM     = wb_sel_EX;
  assign mem_op         = mem_re_EX | mem_we_EX;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    ack_take  = 1'b0;
    tmo_hit   = 1'b0;
    mem_stall = 1'b0;
    case (state)
      S_IDLE: begin
        // A memory op stalls even while ext_stall holds off the issue.
        mem_stall = mem_op;
        if (mem_op && !ext_stall) begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // ext_stall is deliberately ignored here: the handshake must finish.
        mem_stall = 1'b1;
        if (mem_ack) begin
          ack_take  = 1'b1;
          state_nxt = S_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Stall is released for one cycle so the op leaves the stage;
        // the same op is still on the inputs, so no re-issue from here.
        if (!ext_stall) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Timeout counter: cleared on issue, counts WAIT cycles without ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (issue) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT && !ack_take && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Request registers: captured once at issue, held stable through WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (issue) begin
      mem_req   <= 1'b1;
      // re&we together is resolved as a store.
      mem_wr    <= mem_we_EX;
      mem_addr  <= alu_result_EX;
      mem_wdata <= sdata_EX;
    end else if (ack_take || tmo_hit) begin
      mem_req   <= 1'b0;
    end
  end

  // Load data: updated only when a read completes (by ack or timeout)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldata_MEM <= '0;
    end else if (ack_take && !mem_wr) begin
      ldata_MEM <= mem_rdata;
    end else if (tmo_hit && !mem_wr) begin
      ldata_MEM <= ERR_DATA;
    end
  end

  // Error pulse: illegal re&we at issue, or timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= (issue & mem_re_EX & mem_we_EX) | tmo_hit;
    end
  end

  // Stall cycle statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (mem_stall) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int DW  = 16;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] alu_result_EX = '0;
  logic [DW-1:0] sdata_EX = '0;
  logic          mem_re_EX = 1'b0;
  logic          mem_we_EX = 1'b0;
  logic          wb_sel_EX = 1'b0;
  logic          ext_stall = 1'b0;
  logic          mem_req;
  logic          mem_wr;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] ldata_MEM;
  logic [DW-1:0] alu_result_MEM;
  logic          wb_sel_MEM;
  logic          mem_stall;
  logic          mem_err;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .DATA_W  (DW),
    .TIMEOUT (TMO),
    .CNT_W   (8),
    .ERR_DATA(16'hDEAD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_result_EX (alu_result_EX),
    .sdata_EX      (sdata_EX),
    .mem_re_EX     (mem_re_EX),
    .mem_we_EX     (mem_we_EX),
    .wb_sel_EX     (wb_sel_EX),
    .ext_stall     (ext_stall),
    .mem_req       (mem_req),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .ldata_MEM     (ldata_MEM),
    .alu_result_MEM(alu_result_MEM),
    .wb_sel_MEM    (wb_sel_MEM),
    .mem_stall     (mem_stall),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic        err;
  } req_t;

  typedef struct {
    logic [15:0] ldata;
    logic [15:0] scnt;
    logic        err;
    int          nw;
  } done_t;

  typedef struct {
    int          ack_cycle;
    logic [15:0] rdata;
  } rsp_t;

  req_t  req_q[$];
  done_t done_q[$];
  rsp_t  rsp_q[$];

  int checks   = 0;
  int failures = 0;

  // Transaction-level reference state
  logic [15:0] m_ldata = 16'h0000;
  int          m_scnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks in WAIT cycle ack_cycle (1 = first cycle mem_req
  // is seen high). Also drives random noise on rdata and stray acks while idle.
  logic        rsp_busy = 1'b0;
  int          rsp_k = 0;
  rsp_t        rsp_cur;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      if (!rst_n) begin
        rsp_busy = 1'b0;
      end else begin
        if (!rsp_busy && mem_req && rsp_q.size() > 0) begin
          rsp_cur  = rsp_q.pop_front();
          rsp_busy = 1'b1;
          rsp_k    = 1;
        end else if (rsp_busy) begin
          rsp_k++;
        end
        if (rsp_busy && rsp_k == rsp_cur.ack_cycle) begin
          mem_ack   = 1'b1;
          mem_rdata = rsp_cur.rdata;
          rsp_busy  = 1'b0;
        end else if (!rsp_busy && !mem_req && $urandom_range(0, 7) == 0) begin
          mem_ack = 1'b1;
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT raises or drops mem_req
  logic mon_prev = 1'b0;
  int   mon_hi   = 0;
  req_t mon_cur;
  initial begin
    done_t dn;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = 1'b0;
        mon_hi   = 0;
        continue;
      end
      chk("alu_pass", alu_result_MEM, alu_result_EX);
      chk("wbsel_pass", wb_sel_MEM, wb_sel_EX);
      if (mem_req && !mon_prev) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          mon_cur = req_q.pop_front();
          chk("req_addr", mem_addr, mon_cur.addr);
          chk("req_wr", mem_wr, mon_cur.wr);
          if (mon_cur.wr) chk("req_wdata", mem_wdata, mon_cur.wdata);
          chk("issue_err", mem_err, mon_cur.err);
        end
        mon_hi = 1;
      end else if (mem_req) begin
        mon_hi++;
        chk("req_addr_stable", mem_addr, mon_cur.addr);
        chk("req_wr_stable", mem_wr, mon_cur.wr);
        if (mon_cur.wr) chk("req_wdata_stable", mem_wdata, mon_cur.wdata);
        chk("wait_err", mem_err, 0);
      end else if (mon_prev) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          dn = done_q.pop_front();
          chk("done_ldata", ldata_MEM, dn.ldata);
          chk("done_err", mem_err, dn.err);
          chk("done_stall_cnt", stall_cnt, dn.scnt);
          chk("req_cycles", mon_hi, dn.nw);
          chk("done_stall", mem_stall, 0);
        end
      end else begin
        chk("idle_err", mem_err, 0);
      end
      mon_prev = mem_req;
    end
  end

  // Non-memory ops: never stall, never request, load data held
  task automatic alu_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_re_EX     = 1'b0;
      mem_we_EX     = 1'b0;
      alu_result_EX = 16'($urandom);
      sdata_EX      = 16'($urandom);
      wb_sel_EX     = 1'($urandom);
      ext_stall     = 1'($urandom);
      #1;
      chk("alu_no_stall", mem_stall, 0);
      chk("alu_no_req", mem_req, 0);
      chk("alu_ldata_hold", ldata_MEM, m_ldata);
      step();
    end
  endtask

  // One load/store. d: ack arrives in WAIT cycle d+1 (timeout if beyond TMO);
  // e: cycles of ext_stall before issue; h: cycles of ext_stall holding DONE.
  task automatic do_op(input logic re, input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rdata,
                       input int d, input int e, input int h);
    req_t  rq;
    done_t dn;
    rsp_t  rs;
    bit    tmo;
    int    nw;
    int    guard;
    tmo = (d + 1 > TMO);
    nw  = tmo ? TMO : d + 1;
    rq.addr  = addr;
    rq.wdata = wdata;
    rq.wr    = we;
    rq.err   = re & we;
    rs.ack_cycle = tmo ? TMO + 1 : d + 1;
    rs.rdata     = rdata;
    m_scnt += e + 1 + nw;
    if (!we) m_ldata = tmo ? 16'hDEAD : rdata;
    dn.ldata = m_ldata;
    dn.err   = tmo;
    dn.scnt  = sat16(m_scnt);
    dn.nw    = nw;
    req_q.push_back(rq);
    done_q.push_back(dn);
    rsp_q.push_back(rs);

    mem_re_EX     = re;
    mem_we_EX     = we;
    alu_result_EX = addr;
    sdata_EX      = wdata;
    wb_sel_EX     = 1'($urandom);
    for (int i = 0; i < e; i++) begin
      ext_stall = 1'b1;
      #1;
      chk("ext_hold_stall", mem_stall, 1);
      chk("ext_hold_noreq", mem_req, 0);
      step();
    end
    ext_stall = 1'b0;
    #1;
    chk("issue_stall", mem_stall, 1);
    step();
    guard = 0;
    while (mem_stall && guard < 40) begin
      ext_stall = 1'($urandom);
      step();
      guard++;
    end
    if (guard >= 40) chk("op_complete_timeout", 0, 1);
    for (int i = 0; i < h; i++) begin
      ext_stall = 1'b1;
      step();
      chk("done_hold_stall", mem_stall, 0);
      chk("done_hold_noreq", mem_req, 0);
    end
    ext_stall = 1'b0;
    step();
    mem_re_EX = 1'b0;
    mem_we_EX = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_wr"}, mem_wr, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_ldata"}, ldata_MEM, 0);
    chk({tag, "_err"}, mem_err, 0);
    chk({tag, "_scnt"}, stall_cnt, 0);
    chk({tag, "_stall"}, mem_stall, 0);
  endtask

  // Reset while a load is waiting on a memory that never answers
  task automatic reset_mid_wait();
    req_t rq;
    rsp_t rs;
    rq.addr = 16'h0080; rq.wdata = 16'h0; rq.wr = 1'b0; rq.err = 1'b0;
    rs.ack_cycle = 1000; rs.rdata = 16'h0;
    req_q.push_back(rq);
    rsp_q.push_back(rs);
    mem_re_EX     = 1'b1;
    mem_we_EX     = 1'b0;
    alu_result_EX = 16'h0080;
    ext_stall     = 1'b0;
    step();
    step();
    #2;
    rst_n     = 1'b0;
    mem_re_EX = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    rsp_q.delete();
    m_scnt  = 0;
    m_ldata = 16'h0000;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int guard;
    step();
    step();
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();

    alu_cycles(3);
    do_op(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1234, 0, 0, 0);
    do_op(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h5555, TMO - 1, 0, 0);
    do_op(1'b0, 1'b1, 16'h0012, 16'hCAFE, 16'h6666, TMO, 1, 0);
    do_op(1'b1, 1'b0, 16'h0044, 16'h0000, 16'h7777, 10, 0, 0);
    alu_cycles(2);
    do_op(1'b1, 1'b0, 16'h0048, 16'h0000, 16'hA5A5, 1, 0, 3);
    do_op(1'b1, 1'b0, 16'h004C, 16'h0000, 16'h0F0F, 0, 0, 0);
    reset_mid_wait();
    alu_cycles(2);
    do_op(1'b1, 1'b0, 16'h0050, 16'h0000, 16'h2468, 2, 0, 0);
    do_op(1'b1, 1'b1, 16'h0060, 16'h1357, 16'h9999, 1, 0, 0);
    alu_cycles(4);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        alu_cycles($urandom_range(1, 3));
      end else begin
        do_op((kind < 6) || (kind == 9), (kind >= 6), 16'($urandom), 16'($urandom),
              16'($urandom), $urandom_range(0, TMO + 2), $urandom_range(0, 2),
              $urandom_range(0, 2));
      end
    end
    alu_cycles(3);

    guard = 0;
    while ((done_q.size() != 0 || req_q.size() != 0) && guard < 50) begin
      step();
      guard++;
    end
    chk("scoreboard_drained", done_q.size() + req_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
